// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared types and constants for the sram_ctrl front end and its
//   response buffer.
//   - state_t : controller state (S_INIT zero-fill, S_READY serving)
//   - rsp_t   : one buffered response {rdata, err}
//   - SRAM_AW / SRAM_DEPTH : geometry of the 16384x32 macro
package sram_ctrl_pkg;

   localparam int SRAM_AW    = 14;
   localparam int SRAM_DEPTH = 16384;

   typedef enum logic [0:0] {
      S_INIT  = 1'b0,
      S_READY = 1'b1
   } state_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

endpackage

// File: rtl/sram_rsp_buf.sv
// sram_rsp_buf
//   Two-entry FIFO holding responses that could not be handed to the
//   consumer in the cycle the macro produced them.
//   Ports:
//     clk, rstn   : clock, asynchronous active-low reset
//     push        : write push_data into the tail (ignored when full)
//     push_data   : response to store
//     pop         : drop the head entry (ignored when empty)
//     head        : oldest stored response
//     count       : number of stored responses, 0..2
module sram_rsp_buf
   import sram_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       push,
   input  rsp_t       push_data,
   input  logic       pop,
   output rsp_t       head,
   output logic [1:0] count
);

   rsp_t       entry0_r;
   rsp_t       entry1_r;
   logic       wr_ptr_r;
   logic       rd_ptr_r;
   logic [1:0] count_r;
   logic       do_push_s;
   logic       do_pop_s;

   // A push into a full buffer is only legal when the head leaves in the same cycle.
   assign do_push_s = push & ((count_r != 2'd2) | pop);
   assign do_pop_s  = pop & (count_r != 2'd0);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         entry0_r <= '0;
         entry1_r <= '0;
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (do_push_s) begin
            if (wr_ptr_r == 1'b0) begin
               entry0_r <= push_data;
            end else begin
               entry1_r <= push_data;
            end
            wr_ptr_r <= ~wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Head selection.
   always_comb begin
      head = entry0_r;
      if (rd_ptr_r == 1'b1) begin
         head = entry1_r;
      end else begin
         head = entry0_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl
//   Valid/ready front end for one 16384x32 single-port sram macro.
//   Accepted requests drive the macro pins in the same cycle; the
//   macro's registered DO is returned the following cycle, either
//   directly or through a 2-entry buffer when the consumer stalls.
//   After reset the array can optionally be zero-filled.
//   Ports:
//     clk, rstn                         : clock, async active-low reset
//     init_done                         : high once requests are accepted
//     req_valid/ready/write/addr/wstrb/wdata : request channel
//     rsp_valid/ready/rdata/err         : response channel (in order)
//     sram_cs/we/a/byte/di, sram_do     : macro pins
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter bit          INIT_ZERO = 1'b1
) (
   input  logic               clk,
   input  logic               rstn,
   output logic               init_done,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [31:0]        req_addr,
   input  logic [3:0]         req_wstrb,
   input  logic [31:0]        req_wdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [31:0]        rsp_rdata,
   output logic               rsp_err,
   output logic               sram_cs,
   output logic               sram_we,
   output logic [SRAM_AW-1:0] sram_a,
   output logic [3:0]         sram_byte,
   output logic [31:0]        sram_di,
   input  logic [31:0]        sram_do
);

   state_t             state_r;
   state_t             state_nxt_s;
   logic [SRAM_AW-1:0] init_cnt_r;
   logic               init_done_r;

   logic               p_r;
   logic               p_is_read_r;
   logic               p_err_r;

   logic               hit_s;
   logic               accept_s;
   logic               req_ready_s;
   logic [1:0]         buf_count_s;
   rsp_t               buf_head_s;
   rsp_t               direct_rsp_s;
   logic               push_s;
   logic               pop_s;
   logic               addr_lsb_unused_s;

   // Byte offset within a word plays no part in word addressing.
   assign addr_lsb_unused_s = ^req_addr[1:0];

   assign hit_s       = (req_addr[31:16] == ADDR_BASE[31:16]);
   // Only registered state feeds req_ready, so it never combinationally
   // depends on rsp_ready or req_valid.
   assign req_ready_s = init_done_r & (({2'b00, p_r} + {1'b0, buf_count_s}) < 3'd2);
   assign accept_s    = req_valid & req_ready_s;
   assign req_ready   = req_ready_s;
   assign init_done   = init_done_r;

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= INIT_ZERO ? S_INIT : S_READY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state: leave zero-fill after the last word is written.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_INIT: begin
            if (init_cnt_r == SRAM_AW'(SRAM_DEPTH - 1)) begin
               state_nxt_s = S_READY;
            end else begin
               state_nxt_s = S_INIT;
            end
         end
         S_READY: state_nxt_s = S_READY;
         default: state_nxt_s = S_INIT;
      endcase
   end

   // FSM outputs: macro pin drive for zero-fill or an accepted hit.
   // Zero-fill writes are gated by rstn so the pins stay idle while reset
   // is held, yet word 0 is written on the very first edge after release.
   always_comb begin
      sram_cs   = 1'b0;
      sram_we   = 1'b0;
      sram_a    = '0;
      sram_byte = 4'h0;
      sram_di   = 32'h0000_0000;
      case (state_r)
         S_INIT: begin
            if (rstn) begin
               sram_cs   = 1'b1;
               sram_we   = 1'b1;
               sram_a    = init_cnt_r;
               sram_byte = 4'hf;
               sram_di   = 32'h0000_0000;
            end else begin
               sram_cs   = 1'b0;
            end
         end
         S_READY: begin
            if (accept_s && hit_s) begin
               sram_cs   = 1'b1;
               sram_we   = req_write;
               sram_a    = req_addr[15:2];
               sram_byte = req_write ? req_wstrb : 4'h0;
               sram_di   = req_wdata;
            end else begin
               sram_cs   = 1'b0;
            end
         end
         default: sram_cs = 1'b0;
      endcase
   end

   // Zero-fill word counter and registered init_done.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         init_cnt_r  <= '0;
         init_done_r <= 1'b0;
      end else begin
         if (state_r == S_INIT) begin
            init_cnt_r <= init_cnt_r + SRAM_AW'(1);
         end else begin
            init_cnt_r <= init_cnt_r;
         end
         init_done_r <= (state_r == S_READY);
      end
   end

   // In-flight flag: the response for this request is due this cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         p_r         <= 1'b0;
         p_is_read_r <= 1'b0;
         p_err_r     <= 1'b0;
      end else begin
         p_r         <= accept_s;
         p_is_read_r <= accept_s & hit_s & ~req_write;
         p_err_r     <= accept_s & ~hit_s;
      end
   end

   // sram_do is only meaningful in the cycle after a read, so it is taken
   // either straight to the consumer or into the buffer in that cycle.
   assign direct_rsp_s.rdata = p_is_read_r ? sram_do : 32'h0000_0000;
   assign direct_rsp_s.err   = p_err_r;

   assign pop_s  = rsp_ready & (buf_count_s != 2'd0);
   assign push_s = p_r & ~(rsp_ready & (buf_count_s == 2'd0));

   sram_rsp_buf u_rsp_buf (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push_s),
      .push_data (direct_rsp_s),
      .pop       (pop_s),
      .head      (buf_head_s),
      .count     (buf_count_s)
   );

   // Response mux: buffered responses are older, so they go first.
   always_comb begin
      rsp_rdata = 32'h0000_0000;
      rsp_err   = 1'b0;
      if (buf_count_s != 2'd0) begin
         rsp_rdata = buf_head_s.rdata;
         rsp_err   = buf_head_s.err;
      end else if (p_r) begin
         rsp_rdata = direct_rsp_s.rdata;
         rsp_err   = direct_rsp_s.err;
      end else begin
         rsp_rdata = 32'h0000_0000;
         rsp_err   = 1'b0;
      end
   end

   assign rsp_valid = (buf_count_s != 2'd0) | p_r;

endmodule

// File: tb/tb_sram_ctrl.sv
`timescale 1ns/1ps
module tb_sram_ctrl;

   localparam logic [31:0] BASE = 32'h2000_0000;

   logic        clk;
   logic        rstn;
   logic        init_done;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        sram_cs;
   logic        sram_we;
   logic [13:0] sram_a;
   logic [3:0]  sram_byte;
   logic [31:0] sram_di;
   logic [31:0] sram_do;

   sram_ctrl #(.ADDR_BASE(BASE), .INIT_ZERO(1'b1)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .init_done (init_done),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wstrb (req_wstrb),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .sram_cs   (sram_cs),
      .sram_we   (sram_we),
      .sram_a    (sram_a),
      .sram_byte (sram_byte),
      .sram_di   (sram_di),
      .sram_do   (sram_do)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural sram macro: byte-masked write at the edge, registered read.
   logic [31:0] mem [16384];
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we) begin
            for (int i = 0; i < 4; i++) begin
               if (sram_byte[i]) mem[sram_a][i*8 +: 8] <= sram_di[i*8 +: 8];
            end
         end else begin
            sram_do <= mem[sram_a];
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc_cyc;
      bit          chk_lat;
   } exp_t;
   exp_t sb[$];

   // Response monitor: pops the scoreboard on every handshake.
   always @(negedge clk) begin
      if (!rstn) begin
         sb.delete();
      end else if (rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            if (e.chk_lat) check("rsp_latency", cyc, e.acc_cyc + 1);
         end
      end
   end

   // Zero-fill monitor: every macro write before init_done must be a zero
   // word at the next sequential address.
   int init_writes;
   int init_bad;
   int init_exp_a;
   always @(negedge clk) begin
      if (!rstn) begin
         init_writes = 0;
         init_bad    = 0;
         init_exp_a  = 0;
      end else if (!init_done && sram_cs) begin
         if (!(sram_we && sram_byte == 4'hf && sram_di == 32'h0 && int'(sram_a) == init_exp_a))
            init_bad++;
         init_writes++;
         init_exp_a++;
      end
   end

   logic        pend_wr;
   logic [31:0] pend_addr;
   logic [3:0]  pend_strb;
   logic [31:0] pend_rdata;
   logic        pend_err;
   bit          lat_en;
   int          stall_cnt;

   task automatic issue_drive(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
      @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_write  = wr;
      req_addr   = addr;
      req_wstrb  = strb;
      req_wdata  = wdata;
      pend_wr    = wr;
      pend_addr  = addr;
      pend_strb  = strb;
      pend_rdata = exp_rdata;
      pend_err   = exp_err;
   endtask

   task automatic issue_wait();
      int budget;
      budget = 0;
      forever begin
         @(negedge clk);
         if (req_ready) begin
            exp_t e;
            check("pin_cs", {31'd0, sram_cs}, {31'd0, ~pend_err});
            if (!pend_err) begin
               check("pin_a", {18'd0, sram_a}, {18'd0, pend_addr[15:2]});
               check("pin_we", {31'd0, sram_we}, {31'd0, pend_wr});
               check("pin_byte", {28'd0, sram_byte}, {28'd0, (pend_wr ? pend_strb : 4'h0)});
            end
            e.rdata   = pend_rdata;
            e.err     = pend_err;
            e.acc_cyc = cyc;
            e.chk_lat = lat_en;
            sb.push_back(e);
            break;
         end
         stall_cnt++;
         budget++;
         if (budget > 50) begin
            check("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
      issue_drive(wr, addr, strb, wdata, exp_rdata, exp_err);
      issue_wait();
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      #2;
      check(name, sb.size(), 0);
   endtask

   task automatic wait_init(input string name);
      int n;
      n = 0;
      while (n < 20000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (init_done) break;
      end
      check({name, "_latency"}, n, 16385);
      check({name, "_writes"}, init_writes, 16384);
      check({name, "_bad"}, init_bad, 0);
   endtask

   function automatic logic [31:0] burst_data(input int i);
      case (i)
         0: return 32'hA000_0001;
         1: return 32'hB111_0002;
         2: return 32'hC222_0003;
         3: return 32'hD333_0004;
         4: return 32'hE444_0005;
         5: return 32'hF555_0006;
         6: return 32'h0666_0007;
         default: return 32'h1777_0008;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn      = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h0;
      req_wstrb = 4'h0;
      req_wdata = 32'h0;
      rsp_ready = 1'b1;
      lat_en    = 1'b1;
      stall_cnt = 0;

      repeat (3) @(negedge clk);
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_sram_cs", {31'd0, sram_cs}, 32'd0);
      check("rst_sram_we", {31'd0, sram_we}, 32'd0);
      check("rst_sram_a", {18'd0, sram_a}, 32'd0);
      check("rst_sram_byte", {28'd0, sram_byte}, 32'd0);
      check("rst_sram_di", sram_di, 32'd0);

      @(posedge clk);
      #2 rstn = 1'b1;
      wait_init("init1");

      // Read after zero-fill, partial write merge, zero-strobe write.
      issue(1'b0, BASE + 32'h100, 4'h0, 32'h0, 32'h0000_0000, 1'b0);
      issue(1'b1, BASE + 32'h10, 4'hf, 32'h1122_3344, 32'h0, 1'b0);
      issue(1'b1, BASE + 32'h10, 4'b0101, 32'hDEAD_BEEF, 32'h0, 1'b0);
      issue(1'b0, BASE + 32'h10, 4'h0, 32'h0, 32'h11AD_33EF, 1'b0);
      issue(1'b1, BASE + 32'h10, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      issue(1'b0, BASE + 32'h10, 4'h0, 32'h0, 32'h11AD_33EF, 1'b0);
      // Back-to-back read-after-write to the same word.
      issue(1'b1, BASE + 32'h20, 4'hf, 32'hCAFE_F00D, 32'h0, 1'b0);
      issue(1'b0, BASE + 32'h20, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
      // Out-of-window read: error, no macro access.
      issue(1'b0, BASE + 32'h1_0000, 4'h0, 32'h0, 32'h0, 1'b1);
      idle();
      check("miss_no_cs", {31'd0, sram_cs}, 32'd0);
      drain("drain_basic");

      // Sustained throughput with rsp_ready high.
      for (int i = 0; i < 8; i++)
         issue(1'b1, BASE + 32'h40 + 32'(4 * i), 4'hf, burst_data(i), 32'h0, 1'b0);
      stall_cnt = 0;
      for (int i = 0; i < 8; i++)
         issue(1'b0, BASE + 32'h40 + 32'(4 * i), 4'h0, 32'h0, burst_data(i), 1'b0);
      idle();
      check("burst_stalls", stall_cnt, 0);
      drain("drain_burst");

      // Back-pressure: two outstanding, third held off until release.
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      lat_en    = 1'b0;
      issue(1'b0, BASE + 32'h40, 4'h0, 32'h0, burst_data(0), 1'b0);
      issue(1'b0, BASE + 32'h44, 4'h0, 32'h0, burst_data(1), 1'b0);
      issue_drive(1'b0, BASE + 32'h48, 4'h0, 32'h0, burst_data(2), 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_ready_low", {31'd0, req_ready}, 32'd0);
         check("bp_valid_high", {31'd0, rsp_valid}, 32'd1);
      end
      check("bp_outstanding", sb.size(), 2);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      issue_wait();
      idle();
      drain("drain_bp");
      lat_en = 1'b1;

      // Reset with two responses pending.
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      issue(1'b0, BASE + 32'h4C, 4'h0, 32'h0, burst_data(3), 1'b0);
      issue(1'b0, BASE + 32'h50, 4'h0, 32'h0, burst_data(4), 1'b0);
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
      check("mid_rst_cs", {31'd0, sram_cs}, 32'd0);
      repeat (3) @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #2 rstn = 1'b1;
      wait_init("init2");
      issue(1'b0, BASE + 32'h40, 4'h0, 32'h0, 32'h0, 1'b0);
      issue(1'b0, BASE + 32'h10, 4'h0, 32'h0, 32'h0, 1'b0);
      idle();
      drain("drain_final");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
